// File: rtl/chip8_pkg.sv
// Shared CHIP-8 keypad types: key count, key index, wait-for-key FSM states.
// Also holds the lowest-set-key helper used by the FX0A capture logic.
package chip8_pkg;

  localparam int NUM_KEYS = 16;

  typedef logic [3:0] key_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    HELD,
    DONE,
    ACK
  } keypad_state_e;

  function automatic key_idx_t lowest_key(input logic [15:0] v);
    key_idx_t k;
    k = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) k = key_idx_t'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/chip8_key_debounce.sv
// One keypad bit: 2-flop synchroniser, tick-sampled history, stable compare.
// Ports: Clk, Reset_n, i_tick (shared sample strobe), i_raw (switch), o_state.
module chip8_key_debounce #(
  parameter int STABLE_SAMPLES = 3
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_state
);

  logic [1:0]                r_sync;
  logic [STABLE_SAMPLES-1:0] r_hist;
  logic                      r_state;
  logic [STABLE_SAMPLES-1:0] w_hist;

  // History including the sample taken on this tick, so a
  // full run of equal samples updates the state on the same edge.
  assign w_hist  = {r_hist[STABLE_SAMPLES-2:0], r_sync[1]};
  assign o_state = r_state;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync  <= '0;
      r_hist  <= '0;
      r_state <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (i_tick) begin
        r_hist <= w_hist;
        if (&w_hist)
          r_state <= 1'b1;
        else if (~|w_hist)
          r_state <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/chip8_keypad.sv
// CHIP-8 keypad conditioner: debounced key_state, EX9E/EXA1 query, FX0A wait.
// Ports: Clk, Reset_n, switches, key_state, query_key/pressed, wait_req/valid/key.
module chip8_keypad #(
  parameter int NUM_KEYS       = 16,
  parameter int TICK_CYCLES    = 500000,
  parameter int STABLE_SAMPLES = 3
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [NUM_KEYS-1:0] switches,
  output logic [NUM_KEYS-1:0] key_state,
  input  logic [3:0]          query_key,
  output logic                query_pressed,
  input  logic                wait_req,
  output logic                wait_valid,
  output logic [3:0]          wait_key
);

  import chip8_pkg::*;

  localparam int CW = $clog2(TICK_CYCLES);

  logic [CW-1:0]       r_cnt;
  logic                w_tick;
  keypad_state_e       r_st;
  keypad_state_e       w_st_nxt;
  logic [NUM_KEYS-1:0] r_blocked;
  logic [NUM_KEYS-1:0] w_blocked_nxt;
  logic [NUM_KEYS-1:0] w_cand;
  key_idx_t            r_wait_key;
  key_idx_t            w_key_nxt;

  assign w_tick = (r_cnt == CW'(TICK_CYCLES - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      r_cnt <= '0;
    else if (w_tick)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CW'(1);
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    chip8_key_debounce #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_db (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .i_tick (w_tick),
      .i_raw  (switches[g]),
      .o_state(key_state[g])
    );
  end

  assign query_pressed = key_state[query_key];

  // Keys held when the wait was armed stay blocked until released.
  assign w_cand = key_state & ~r_blocked;

  always_comb begin
    w_st_nxt      = r_st;
    w_blocked_nxt = r_blocked;
    w_key_nxt     = r_wait_key;
    unique case (r_st)
      IDLE: begin
        if (wait_req) begin
          w_st_nxt      = ARMED;
          w_blocked_nxt = key_state;
        end
      end
      ARMED: begin
        w_blocked_nxt = r_blocked & key_state;
        if (!wait_req) begin
          w_st_nxt = IDLE;
        end else if (|w_cand) begin
          w_key_nxt = lowest_key(16'(w_cand));
          w_st_nxt  = HELD;
        end
      end
      HELD: begin
        if (!wait_req)
          w_st_nxt = IDLE;
        else if (!key_state[r_wait_key])
          w_st_nxt = DONE;
      end
      DONE: w_st_nxt = ACK;
      ACK: begin
        if (!wait_req) w_st_nxt = IDLE;
      end
      default: w_st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_st       <= IDLE;
      r_blocked  <= '0;
      r_wait_key <= '0;
    end else begin
      r_st       <= w_st_nxt;
      r_blocked  <= w_blocked_nxt;
      r_wait_key <= w_key_nxt;
    end
  end

  assign wait_valid = (r_st == DONE);
  assign wait_key   = r_wait_key;

endmodule
